// File: rtl/fir_pkg.sv
// fir_pkg: shared types and defaults for the FIR coefficient path.
// Loader state encoding, default widths and a counter-width helper.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        READY
    } coeff_ld_state_t;

    localparam int FIR_DATA_WIDTH   = 16;
    localparam int FIR_DATA_WIDTH_F = 14;

    // Width of a counter/index able to address n entries (at least 1 bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// fir_coeff_bank: shadow and active coefficient register arrays.
// Shadow takes single/mirrored writes; active copies shadow on commit.
module fir_coeff_bank #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_TAPS   = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           wr_en,
    input  logic [ADDR_WIDTH-1:0]          addr,
    input  logic [DATA_WIDTH-1:0]          data,
    input  logic                           mirror,
    input  logic                           commit,
    output logic [NUM_TAPS*DATA_WIDTH-1:0] h_out
);

    logic [DATA_WIDTH-1:0] shadow [NUM_TAPS];
    logic [DATA_WIDTH-1:0] active [NUM_TAPS];

    // Shadow write: tap addr, plus its mirror image when mirroring.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                shadow[k] <= '0;
            end
        end else if (wr_en) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                if (int'(addr) == k ||
                    (mirror && int'(addr) == NUM_TAPS - 1 - k)) begin
                    shadow[k] <= data;
                end
            end
        end
    end

    // Active bank only changes on commit, so reloads never disturb taps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                active[k] <= '0;
            end
        end else if (commit) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                active[k] <= shadow[k];
            end
        end
    end

    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
        assign h_out[k*DATA_WIDTH +: DATA_WIDTH] = active[k];
    end

endmodule

// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader: streams coefficients into a shadow bank, commits to taps.
// Define FIR_COEFF_SYMMETRIC_EN to load half the taps and mirror them.
module fir_coeff_loader
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = FIR_DATA_WIDTH,
    parameter int NUM_TAPS   = 8
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           load_start,
    input  logic [DATA_WIDTH-1:0]          coeff_in,
    input  logic                           coeff_valid,
    output logic                           coeff_ready,
    input  logic                           commit,
    output logic                           load_done,
    output logic                           busy,
    output logic [NUM_TAPS*DATA_WIDTH-1:0] h_out
);

    localparam int AW = cnt_width(NUM_TAPS);

`ifdef FIR_COEFF_SYMMETRIC_EN
    localparam int LOAD_LEN = (NUM_TAPS + 1) / 2;
    localparam logic MIRROR = 1'b1;
`else
    localparam int LOAD_LEN = NUM_TAPS;
    localparam logic MIRROR = 1'b0;
`endif

    localparam logic [AW-1:0] LAST = AW'(LOAD_LEN - 1);

    coeff_ld_state_t state, state_d;
    logic [AW-1:0]   count, count_d;
    logic            done_d;
    logic            wr_en;
    logic            commit_en;
    logic            accept;

    assign busy        = (state == LOAD);
    assign coeff_ready = busy;
    assign accept      = coeff_valid && coeff_ready;

    // State, beat counter and done pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            count     <= '0;
            load_done <= 1'b0;
        end else begin
            state     <= state_d;
            count     <= count_d;
            load_done <= done_d;
        end
    end

    // Next state: load_start always restarts, and wins over a same-cycle beat.
    always_comb begin
        state_d   = state;
        count_d   = count;
        done_d    = 1'b0;
        wr_en     = 1'b0;
        commit_en = 1'b0;
        unique case (state)
            IDLE: begin
                if (load_start) begin
                    state_d = LOAD;
                    count_d = '0;
                end
            end
            LOAD: begin
                if (load_start) begin
                    count_d = '0;
                end else if (accept) begin
                    wr_en = 1'b1;
                    if (count == LAST) begin
                        state_d = READY;
                        count_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        count_d = count + 1'b1;
                    end
                end
            end
            READY: begin
                if (commit) begin
                    commit_en = 1'b1;
                    state_d   = IDLE;
                end
                if (load_start) begin
                    state_d = LOAD;
                    count_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    fir_coeff_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_TAPS   (NUM_TAPS),
        .ADDR_WIDTH (AW)
    ) u_bank (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .addr    (count),
        .data    (coeff_in),
        .mirror  (MIRROR),
        .commit  (commit_en),
        .h_out   (h_out)
    );

endmodule

// File: tb/tb_fir_coeff_loader.sv
// tb_fir_coeff_loader: directed checks of load, restart, commit and mirroring.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_fir_coeff_loader;

    localparam int DW = 16;
`ifdef FIR_COEFF_SYMMETRIC_EN
    localparam int NT = 7;
    localparam int LL = 4;
`else
    localparam int NT = 8;
    localparam int LL = 8;
`endif

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              load_start = 1'b0;
    logic [DW-1:0]     coeff_in = '0;
    logic              coeff_valid = 1'b0;
    logic              coeff_ready;
    logic              commit = 1'b0;
    logic              load_done;
    logic              busy;
    logic [NT*DW-1:0]  h_out;

    int passed = 0;
    int total  = 0;
    int done_seen = 0;

    logic [DW-1:0]    bank [NT];
    logic [NT*DW-1:0] exp_h;

    always #5 clk = ~clk;

    fir_coeff_loader #(
        .DATA_WIDTH (DW),
        .NUM_TAPS   (NT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .load_start  (load_start),
        .coeff_in    (coeff_in),
        .coeff_valid (coeff_valid),
        .coeff_ready (coeff_ready),
        .commit      (commit),
        .load_done   (load_done),
        .busy        (busy),
        .h_out       (h_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        if (load_done) done_seen++;
    endtask

    function automatic logic [NT*DW-1:0] pack_bank();
        logic [NT*DW-1:0] r;
        for (int k = 0; k < NT; k++) r[k*DW +: DW] = bank[k];
        return r;
    endfunction

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] v);
        coeff_valid = 1'b1;
        coeff_in = v;
        tick();
        coeff_valid = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (h_out !== '0) $display("FAIL rst_h_out got %h exp 0", h_out);
        else passed++;
        total++;
        if (coeff_ready !== 1'b0) $display("FAIL rst_ready got %b exp 0", coeff_ready);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy);
        else passed++;
        total++;
        if (load_done !== 1'b0) $display("FAIL rst_done got %b exp 0", load_done);
        else passed++;
        reset_n = 1'b1;
        tick();
        // Reset in the middle of a load.
        start_load();
        send(16'h0011);
        send(16'h0022);
        send(16'h0033);
        reset_n = 1'b0;
        #2;
        total++;
        if (coeff_ready !== 1'b0) $display("FAIL mid_rst_ready got %b exp 0", coeff_ready);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL mid_rst_busy got %b exp 0", busy);
        else passed++;
        tick();
        reset_n = 1'b1;
        tick();
        total++;
        if (h_out !== '0) $display("FAIL mid_rst_h_out got %h exp 0", h_out);
        else passed++;
        // Fresh load must start at tap 0.
        start_load();
        for (int k = 0; k < LL; k++) send(DW'(16'h1000 + k));
        do_commit();
        for (int k = 0; k < NT; k++) begin
            bank[k] = (k < LL) ? DW'(16'h1000 + k) : DW'(16'h1000 + NT - 1 - k);
        end
        exp_h = pack_bank();
        total++;
        if (h_out !== exp_h) $display("FAIL post_rst_load got %h exp %h", h_out, exp_h);
        else passed++;
    endtask

    task automatic test_load();
        int acc = 0;
        int pulses = 0;
        int last_i = -1;
        int done_i = -2;
        logic hs;
        logic [NT*DW-1:0] old_h;
        old_h = exp_h;
        start_load();
        for (int i = 0; i < 24; i++) begin
            coeff_valid = (i % 2 == 0);
            coeff_in = DW'(16'h0100 * (acc + 1));
            hs = coeff_valid && coeff_ready;
            tick();
            if (hs) begin
                acc++;
                last_i = i;
            end
            if (load_done) begin
                pulses++;
                done_i = i;
            end
        end
        coeff_valid = 1'b0;
        total++;
        if (acc !== 8) $display("FAIL accepts got %0d exp 8", acc);
        else passed++;
        total++;
        if (pulses !== 1) $display("FAIL done_pulses got %0d exp 1", pulses);
        else passed++;
        total++;
        if (done_i !== last_i) $display("FAIL done_timing got %0d exp %0d", done_i, last_i);
        else passed++;
        total++;
        if (h_out !== old_h) $display("FAIL h_before_commit got %h exp %h", h_out, old_h);
        else passed++;
        total++;
        if (coeff_ready !== 1'b0) $display("FAIL ready_in_ready got %b exp 0", coeff_ready);
        else passed++;
        do_commit();
        for (int k = 0; k < NT; k++) bank[k] = DW'(16'h0100 * (k + 1));
        exp_h = pack_bank();
        total++;
        if (h_out !== exp_h) $display("FAIL load_commit got %h exp %h", h_out, exp_h);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL busy_after_commit got %b exp 0", busy);
        else passed++;
    endtask

    task automatic test_restart();
        logic [DW-1:0] seq [8];
        seq = '{16'h7FFF, 16'h4000, 16'h0001, 16'h0000,
                16'hFFFF, 16'hC000, 16'h8001, 16'h8000};
        done_seen = 0;
        start_load();
        for (int k = 0; k < 5; k++) send(DW'(16'hAAA0 + k));
        load_start = 1'b1;
        coeff_valid = 1'b1;
        coeff_in = 16'hDEAD;
        tick();
        load_start = 1'b0;
        coeff_valid = 1'b0;
        total++;
        if (done_seen !== 0) $display("FAIL restart_early_done got %0d exp 0", done_seen);
        else passed++;
        for (int k = 0; k < 8; k++) send(seq[k]);
        total++;
        if (done_seen !== 1) $display("FAIL restart_done got %0d exp 1", done_seen);
        else passed++;
        do_commit();
        for (int k = 0; k < NT; k++) bank[k] = seq[k];
        exp_h = pack_bank();
        total++;
        if (h_out !== exp_h) $display("FAIL restart_bank got %h exp %h", h_out, exp_h);
        else passed++;
    endtask

    task automatic test_commit();
        logic [NT*DW-1:0] old_h;
        old_h = exp_h;
        do_commit();
        total++;
        if (h_out !== old_h) $display("FAIL commit_idle got %h exp %h", h_out, old_h);
        else passed++;
        start_load();
        send(16'h1234);
        send(16'h1234);
        do_commit();
        total++;
        if (h_out !== old_h) $display("FAIL commit_load got %h exp %h", h_out, old_h);
        else passed++;
        total++;
        if (busy !== 1'b1) $display("FAIL busy_in_load got %b exp 1", busy);
        else passed++;
        for (int k = 0; k < 6; k++) send(DW'(16'h2000 + k));
        bank[0] = 16'h1234;
        bank[1] = 16'h1234;
        for (int k = 2; k < NT; k++) bank[k] = DW'(16'h2000 + k - 2);
        exp_h = pack_bank();
        commit = 1'b1;
        load_start = 1'b1;
        tick();
        commit = 1'b0;
        load_start = 1'b0;
        total++;
        if (h_out !== exp_h) $display("FAIL commit_start_h got %h exp %h", h_out, exp_h);
        else passed++;
        total++;
        if (busy !== 1'b1) $display("FAIL commit_start_busy got %b exp 1", busy);
        else passed++;
    endtask

    task automatic test_filter();
        int x [NT];
        int y;
        int bad = 0;
        logic [DW-1:0] nb [NT];
        for (int k = 0; k < NT; k++) x[k] = 0;
        for (int k = 0; k < NT; k++) nb[k] = DW'(16'hF000 + k);
        start_load();
        for (int c = 0; c < 2 * NT + 8; c++) begin
            if (c == NT + 4) begin
                commit = 1'b1;
                for (int k = 0; k < NT; k++) bank[k] = nb[k];
            end
            coeff_valid = (c < NT);
            coeff_in = (c < NT) ? nb[c] : '0;
            tick();
            commit = 1'b0;
            coeff_valid = 1'b0;
            for (int k = NT - 1; k > 0; k--) x[k] = x[k-1];
            x[0] = (c % NT == 0) ? 1 : 0;
            y = 0;
            for (int k = 0; k < NT; k++) begin
                y += int'($signed(h_out[k*DW +: DW])) * x[k];
            end
            if (y != int'($signed(bank[c % NT]))) bad++;
        end
        total++;
        if (bad !== 0) $display("FAIL filter_stable got %0d bad outputs exp 0", bad);
        else passed++;
    endtask

`ifdef FIR_COEFF_SYMMETRIC_EN
    task automatic test_symmetric();
        start_load();
        send(16'd1);
        send(16'd2);
        send(16'd3);
        total++;
        if (load_done !== 1'b0) $display("FAIL sym_done_early got %b exp 0", load_done);
        else passed++;
        send(16'd4);
        total++;
        if (load_done !== 1'b1) $display("FAIL sym_done got %b exp 1", load_done);
        else passed++;
        do_commit();
        bank = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd3, 16'd2, 16'd1};
        exp_h = pack_bank();
        total++;
        if (h_out !== exp_h) $display("FAIL sym_bank got %h exp %h", h_out, exp_h);
        else passed++;
    endtask
`endif

    initial begin
        test_reset();
`ifdef FIR_COEFF_SYMMETRIC_EN
        test_symmetric();
`else
        test_load();
        test_restart();
        test_commit();
        test_filter();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
